jtframe_ram_rq_rnd: RTL and testbench
=====================================

// Module: jtframe_ram_rq_rnd
// PURPOSE
//  Single-slot SDRAM request generator plus a free-running 16-bit LFSR. The slot
//  turns a chip-select/address pair into a req/req_rnw strobe toward the SDRAM
//  controller, then returns the selected read word with a data_ok strobe. The
//  LFSR supplies pseudo-random values for delays, write selection and stimulus.
//  Sits between a client (CPU, video fetch, test engine) and the SDRAM arbiter.
// PARAMETERS
//  AW  22  address width (client and SDRAM word address)
//  DW  16  client data width: 8, 16 or 32
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset (one clock domain)
//  addr        in   AW  client address
//  offset      in   AW  region base added to addr
//  addr_ok     in   1   client chip select, addr valid while high
//  wrin        in   1   1=write request, 0=read; sampled when request launches
//  wrdin       in   DW  client write data
//  we          in   1   arbiter grants/serves this slot (high ack..rdy)
//  din         in   32  SDRAM read burst data
//  din_ok      in   1   din valid strobe from SDRAM controller
//  req         out  1   request pending toward arbiter
//  req_rnw     out  1   1=read, 0=write; valid while req high
//  sdram_addr  out  AW  latched addr+offset
//  wrdata      out  DW  latched write data
//  data_ok     out  1   dout valid for current addr_ok cycle
//  dout        out  DW  read data to client
//  adv         in   1   LFSR advance enable
//  lfsr        out  16  LFSR state
// BEHAVIOUR
//  Reset (rst_n low, async): req=0, req_rnw=1, data_ok=0, dout=0, sdram_addr=0,
//   wrdata=0, internal last_cs=0, pending=0, lfsr=16'hACE1. Reset mid-request
//   abandons it; nothing resumes after release.
//  Launch: when idle (pending=0) and (addr_ok & ~last_cs, or addr_ok high with
//   addr != last launched addr): next cycle req=1, pending=1, req_rnw=~wrin,
//   sdram_addr=(addr+offset) mod 2^AW, wrdata=wrdin, data_ok=0.
//  last_cs registers addr_ok every cycle.
//  Grant: first cycle with we=1 while req=1 -> req=0 next cycle (pending stays).
//  Completion: pending & we & din_ok -> pending=0; dout latched; data_ok=1 next
//   cycle only if addr_ok still high. Writes complete the same way (din ignored
//   for dout, dout keeps last value, data_ok still pulses).
//  dout select: DW=32 din; DW=16 din[15:0]; DW=8 din[7:0] if sdram_addr[0]=0
//   else din[15:8].
//  data_ok stays high while addr_ok high and addr unchanged; cleared the cycle
//   after addr_ok falls or a new launch occurs.
//  addr_ok falling while pending: request is not aborted; it completes but
//   data_ok is suppressed. din_ok without we, or without pending, is ignored.
//  Rising addr_ok and completion in same cycle: completion wins; launch happens
//   next idle cycle if addr_ok still high.
//  LFSR: Fibonacci, x^16+x^14+x^13+x^11+1; when adv=1:
//   lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}; holds when
//   adv=0. Never reaches 0; period 65535.
// TESTING
//  Read: offset=0, addr=22'h00_1234, addr_ok 0->1, wrin=0 -> req=1, req_rnw=1,
//   sdram_addr=22'h1234; we=1 then din=32'hBEEF_5A5A, din_ok=1 -> data_ok=1,
//   dout=16'h5A5A.
//  Offset wrap: addr=22'h3F_FFFF, offset=22'h2 -> sdram_addr=22'h00_0001.
//  Write: wrin=1, wrdin=16'hC0DE -> req_rnw=0, wrdata=16'hC0DE; completion
//   pulses data_ok, dout unchanged.
//  Abort: addr_ok drops before din_ok -> req still served, data_ok stays 0.
//  Stray din_ok with we=0 -> no state change; async rst_n low mid-request ->
//   req=0, data_ok=0 immediately.
//  LFSR: after reset lfsr=16'hACE1; with adv=1 returns to 16'hACE1 after
//   exactly 65535 cycles, never 0; adv=0 freezes value.

Source files
------------

// File: rtl/jtframe_ram_rq_rnd.sv
// Single-slot SDRAM request generator with read-data return, plus a
// free-running 16-bit Fibonacci LFSR for pseudo-random delays and stimulus.
module jtframe_ram_rq_rnd #(
    parameter int AW = 22,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] offset,
    input  logic          addr_ok,
    input  logic          wrin,
    input  logic [DW-1:0] wrdin,
    input  logic          we,
    input  logic [31:0]   din,
    input  logic          din_ok,
    output logic          req,
    output logic          req_rnw,
    output logic [AW-1:0] sdram_addr,
    output logic [DW-1:0] wrdata,
    output logic          data_ok,
    output logic [DW-1:0] dout,
    input  logic          adv,
    output logic [15:0]   lfsr
);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic          last_cs;
    logic          pending;
    logic          cs_drop;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] rd_word;
    logic          launch;
    logic          done;

    // A new request starts on a chip-select rising edge or on an address
    // change while selected, but only once the previous one has completed.
    assign launch = ~pending & addr_ok & (~last_cs | (addr != last_addr));
    assign done   = pending & we & din_ok;

    generate
        if (DW == 8) begin : g_byte
            assign rd_word = sdram_addr[0] ? din[15:8] : din[7:0];
        end else begin : g_word
            assign rd_word = din[DW-1:0];
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cs    <= 1'b0;
            pending    <= 1'b0;
            cs_drop    <= 1'b0;
            last_addr  <= '0;
            req        <= 1'b0;
            req_rnw    <= 1'b1;
            sdram_addr <= '0;
            wrdata     <= '0;
            data_ok    <= 1'b0;
            dout       <= '0;
        end else begin
            last_cs <= addr_ok;
            if (launch) begin
                pending    <= 1'b1;
                cs_drop    <= 1'b0;
                req        <= 1'b1;
                req_rnw    <= ~wrin;
                last_addr  <= addr;
                sdram_addr <= addr + offset;
                wrdata     <= wrdin;
                data_ok    <= 1'b0;
            end else begin
                if (req && we) begin
                    req <= 1'b0;
                end
                // A deselect during the access suppresses data_ok even if the
                // client reselects the same address before completion.
                if (pending && !addr_ok) begin
                    cs_drop <= 1'b1;
                end
                if (done) begin
                    pending <= 1'b0;
                    if (req_rnw) begin
                        dout <= rd_word;
                    end
                    data_ok <= addr_ok & ~cs_drop & (addr == last_addr);
                end else if (!addr_ok) begin
                    data_ok <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (adv) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

endmodule

// File: tb/tb_jtframe_ram_rq_rnd.sv
// Directed bench for jtframe_ram_rq_rnd: read/write slot behaviour with a
// read-data scoreboard, byte-lane selection and the LFSR sequence/period.
module tb_jtframe_ram_rq_rnd;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr, offset;
    logic          addr_ok, wrin, we, din_ok, adv;
    logic [15:0]   wrdin;
    logic [31:0]   din;

    logic          req, req_rnw, data_ok;
    logic [AW-1:0] sdram_addr;
    logic [15:0]   wrdata, dout, lfsr;

    logic          req8, req_rnw8, data_ok8;
    logic [AW-1:0] sdram_addr8;
    logic [7:0]    wrdata8, dout8, wrdin8;
    logic [15:0]   lfsr8;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp8_q[$];

    assign wrdin8 = wrdin[7:0];

    always #5 clk = ~clk;

    jtframe_ram_rq_rnd #(.AW(AW), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .offset(offset),
        .addr_ok(addr_ok), .wrin(wrin), .wrdin(wrdin), .we(we),
        .din(din), .din_ok(din_ok), .req(req), .req_rnw(req_rnw),
        .sdram_addr(sdram_addr), .wrdata(wrdata), .data_ok(data_ok),
        .dout(dout), .adv(adv), .lfsr(lfsr)
    );

    jtframe_ram_rq_rnd #(.AW(AW), .DW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .offset(offset),
        .addr_ok(addr_ok), .wrin(wrin), .wrdin(wrdin8), .we(we),
        .din(din), .din_ok(din_ok), .req(req8), .req_rnw(req_rnw8),
        .sdram_addr(sdram_addr8), .wrdata(wrdata8), .data_ok(data_ok8),
        .dout(dout8), .adv(adv), .lfsr(lfsr8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops the scoreboard when a read result is due and compares it.
    task automatic expect_data(input string tag);
        logic [15:0] e16;
        logic [7:0]  e8;
        check({tag, "_data_ok"}, {31'd0, data_ok}, 32'd1);
        if (exp_q.size() == 0 || exp8_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e16 = exp_q.pop_front();
            e8  = exp8_q.pop_front();
            check({tag, "_dout"}, {16'd0, dout}, {16'd0, e16});
            check({tag, "_dout8"}, {24'd0, dout8}, {24'd0, e8});
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    initial begin
        logic [15:0] model;
        int          count;
        logic        seen_zero;

        rst_n = 1'b0; addr = '0; offset = '0; addr_ok = 1'b0; wrin = 1'b0;
        wrdin = '0; we = 1'b0; din = '0; din_ok = 1'b0; adv = 1'b0;
        step();
        step();
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_req_rnw", {31'd0, req_rnw}, 32'd1);
        check("rst_data_ok", {31'd0, data_ok}, 32'd0);
        check("rst_dout", {16'd0, dout}, 32'd0);
        check("rst_sdram_addr", {10'd0, sdram_addr}, 32'd0);
        check("rst_wrdata", {16'd0, wrdata}, 32'd0);
        check("rst_lfsr", {16'd0, lfsr}, 32'h0000_ACE1);
        rst_n = 1'b1;
        step();

        // Plain read
        addr = 22'h00_1234; offset = '0; wrin = 1'b0; addr_ok = 1'b1;
        exp_q.push_back(16'h5A5A); exp8_q.push_back(8'h5A);
        step();
        check("rd_req", {31'd0, req}, 32'd1);
        check("rd_req_rnw", {31'd0, req_rnw}, 32'd1);
        check("rd_sdram_addr", {10'd0, sdram_addr}, 32'h0000_1234);
        check("rd_data_ok_low", {31'd0, data_ok}, 32'd0);
        we = 1'b1;
        step();
        check("rd_grant_req", {31'd0, req}, 32'd0);
        check("rd_wait_data_ok", {31'd0, data_ok}, 32'd0);
        din = 32'hBEEF_5A5A; din_ok = 1'b1;
        step();
        expect_data("rd");
        we = 1'b0; din_ok = 1'b0;
        step();
        check("rd_hold_data_ok", {31'd0, data_ok}, 32'd1);
        check("rd_no_relaunch", {31'd0, req}, 32'd0);

        // Address change while selected relaunches; offset sum wraps
        addr = 22'h3F_FFFF; offset = 22'h2;
        exp_q.push_back(16'hABCD); exp8_q.push_back(8'hAB);
        step();
        check("wrap_req", {31'd0, req}, 32'd1);
        check("wrap_sdram_addr", {10'd0, sdram_addr}, 32'h0000_0001);
        check("wrap_data_ok_cleared", {31'd0, data_ok}, 32'd0);
        we = 1'b1; din = 32'h1234_ABCD; din_ok = 1'b1;
        step();
        check("wrap_req_low", {31'd0, req}, 32'd0);
        expect_data("wrap");
        we = 1'b0; din_ok = 1'b0; addr_ok = 1'b0;
        step();
        check("deselect_data_ok", {31'd0, data_ok}, 32'd0);

        // Write: dout keeps last read value, data_ok still pulses
        addr = 22'h00_0100; offset = '0; wrin = 1'b1; wrdin = 16'hC0DE; addr_ok = 1'b1;
        exp_q.push_back(16'hABCD); exp8_q.push_back(8'hAB);
        step();
        check("wr_req", {31'd0, req}, 32'd1);
        check("wr_req_rnw", {31'd0, req_rnw}, 32'd0);
        check("wr_wrdata", {16'd0, wrdata}, 32'h0000_C0DE);
        check("wr_wrdata8", {24'd0, wrdata8}, 32'h0000_00DE);
        we = 1'b1; din = 32'hFFFF_FFFF; din_ok = 1'b1;
        step();
        expect_data("wr");
        we = 1'b0; din_ok = 1'b0; addr_ok = 1'b0; wrin = 1'b0;
        step();

        // Deselect before din_ok: request still served, data_ok suppressed
        addr = 22'h00_0200; addr_ok = 1'b1;
        step();
        check("abort_req", {31'd0, req}, 32'd1);
        addr_ok = 1'b0;
        step();
        check("abort_req_held", {31'd0, req}, 32'd1);
        we = 1'b1; din = 32'h0000_7777; din_ok = 1'b1;
        step();
        check("abort_req_served", {31'd0, req}, 32'd0);
        check("abort_data_ok", {31'd0, data_ok}, 32'd0);
        check("abort_dout", {16'd0, dout}, 32'h0000_7777);
        we = 1'b0; din = 32'h0000_1111;

        // Stray din_ok with nothing pending
        step();
        check("stray_idle_data_ok", {31'd0, data_ok}, 32'd0);
        check("stray_idle_dout", {16'd0, dout}, 32'h0000_7777);
        din_ok = 1'b0;

        // Stray din_ok without we while pending, then async reset mid-request
        addr = 22'h00_0300; addr_ok = 1'b1;
        step();
        check("stray_launch_req", {31'd0, req}, 32'd1);
        din_ok = 1'b1;
        step();
        check("stray_nowe_req", {31'd0, req}, 32'd1);
        check("stray_nowe_data_ok", {31'd0, data_ok}, 32'd0);
        check("stray_nowe_dout", {16'd0, dout}, 32'h0000_7777);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, req}, 32'd0);
        check("async_rst_data_ok", {31'd0, data_ok}, 32'd0);
        check("async_rst_dout", {16'd0, dout}, 32'd0);
        addr_ok = 1'b0; din_ok = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_req", {31'd0, req}, 32'd0);

        // LFSR
        check("lfsr_seed", {16'd0, lfsr}, 32'h0000_ACE1);
        step();
        step();
        check("lfsr_frozen", {16'd0, lfsr}, 32'h0000_ACE1);
        adv = 1'b1;
        step();
        check("lfsr_first", {16'd0, lfsr}, 32'h0000_59C3);
        model = 16'h59C3;
        for (int i = 0; i < 4; i++) begin
            step();
            model = lfsr_next(model);
        end
        check("lfsr_model", {16'd0, lfsr}, {16'd0, model});
        check("lfsr8_match", {16'd0, lfsr8}, {16'd0, model});
        adv = 1'b0;
        step();
        step();
        check("lfsr_hold", {16'd0, lfsr}, {16'd0, model});

        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        adv = 1'b1;
        count = 0;
        seen_zero = 1'b0;
        do begin
            step();
            count++;
            if (lfsr == 16'h0000) seen_zero = 1'b1;
        end while (lfsr != 16'hACE1 && count < 70000);
        adv = 1'b0;
        check("lfsr_period", count, 32'd65535);
        check("lfsr_never_zero", {31'd0, seen_zero}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
